// File: rtl/denoise_blend_axis.sv
// Temporal denoise: joins previous/current frame AXI4-Stream beats and applies a
// per-channel motion-gated recursive blend through a two-stage pipeline.
module denoise_blend_axis #(
    parameter int CH      = 3,
    parameter int PIX_W   = 8,
    parameter int ALPHA_W = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CH*PIX_W-1:0]   s_prev_axis_tdata,
    input  logic                  s_prev_axis_tvalid,
    output logic                  s_prev_axis_tready,
    input  logic                  s_prev_axis_tlast,
    input  logic                  s_prev_axis_tuser,
    input  logic [CH*PIX_W-1:0]   s_curr_axis_tdata,
    input  logic                  s_curr_axis_tvalid,
    output logic                  s_curr_axis_tready,
    input  logic                  s_curr_axis_tlast,
    input  logic                  s_curr_axis_tuser,
    output logic [CH*PIX_W-1:0]   m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic [1:0]            cfg_mode,
    input  logic [ALPHA_W-1:0]    cfg_alpha,
    input  logic [PIX_W-1:0]      cfg_thresh,
    input  logic                  err_clr,
    output logic [1:0]            err_flags,
    output logic [15:0]           frame_cnt
);

    localparam int DW = CH * PIX_W;
    localparam int SW = PIX_W + 1;
    localparam int PW = PIX_W + ALPHA_W + 2;

    logic                 en;
    logic                 acc;
    logic                 cfg_load;

    logic [1:0]           mode_q,   mode_d;
    logic [ALPHA_W-1:0]   alpha_q,  alpha_d;
    logic [PIX_W-1:0]     thresh_q, thresh_d;

    logic                 s1_valid_q;
    logic [DW-1:0]        s1_c_q, s1_p_q, s1_ad_q, s1_ad_d;
    logic [CH*SW-1:0]     s1_d_q, s1_d_d;
    logic                 s1_last_q, s1_user_q;

    logic                 m_valid_q, m_last_q, m_user_q;
    logic [DW-1:0]        m_data_q, m_data_d;

    logic [1:0]           err_q, err_d, err_set;
    logic [15:0]          frame_cnt_q;

    assign en       = !m_valid_q | m_axis_tready;
    assign acc      = aresetn & en & s_prev_axis_tvalid & s_curr_axis_tvalid;
    assign cfg_load = acc & s_curr_axis_tuser;

    assign s_prev_axis_tready = acc;
    assign s_curr_axis_tready = acc;

    // A new frame's configuration applies to its own SOF beat.
    always_comb begin
        mode_d   = cfg_load ? cfg_mode   : mode_q;
        alpha_d  = cfg_load ? cfg_alpha  : alpha_q;
        thresh_d = cfg_load ? cfg_thresh : thresh_q;
    end

    logic [SW-1:0] dif_c, neg_c;
    always_comb begin
        s1_d_d  = '0;
        s1_ad_d = '0;
        dif_c   = '0;
        neg_c   = '0;
        for (int i = 0; i < CH; i++) begin
            dif_c = {1'b0, s_curr_axis_tdata[i*PIX_W +: PIX_W]}
                  - {1'b0, s_prev_axis_tdata[i*PIX_W +: PIX_W]};
            neg_c = SW'(0) - dif_c;
            s1_d_d[i*SW +: SW]        = dif_c;
            s1_ad_d[i*PIX_W +: PIX_W] = dif_c[PIX_W] ? neg_c[PIX_W-1:0] : dif_c[PIX_W-1:0];
        end
    end

    // The shadow registers only change on an accepted beat, which also refills
    // S1, so while S1 holds a valid beat the shadow values are that beat's.
    logic signed [PW-1:0] dx, ax, prod, shf, sum;
    logic [PIX_W-1:0]     cv, pv, adv, blend;
    always_comb begin
        m_data_d = '0;
        dx = '0; ax = '0; prod = '0; shf = '0; sum = '0;
        cv = '0; pv = '0; adv = '0; blend = '0;
        for (int i = 0; i < CH; i++) begin
            cv    = s1_c_q[i*PIX_W +: PIX_W];
            pv    = s1_p_q[i*PIX_W +: PIX_W];
            adv   = s1_ad_q[i*PIX_W +: PIX_W];
            dx    = {{(PW-SW){s1_d_q[i*SW+SW-1]}}, s1_d_q[i*SW +: SW]};
            ax    = {{(PW-ALPHA_W){1'b0}}, alpha_q};
            prod  = dx * ax;
            shf   = prod >>> ALPHA_W;
            sum   = {{(PW-PIX_W){1'b0}}, pv} + shf;
            blend = sum[PIX_W-1:0];
            unique case (mode_q)
                2'd0: m_data_d[i*PIX_W +: PIX_W] = cv;
                2'd1: m_data_d[i*PIX_W +: PIX_W] = pv;
                2'd2: m_data_d[i*PIX_W +: PIX_W] = (adv > thresh_q) ? cv : blend;
                default: m_data_d[i*PIX_W +: PIX_W] = adv;
            endcase
        end
    end

    // A clear is ignored whenever a new mismatch arrives in the same cycle.
    always_comb begin
        err_set = acc ? {s_prev_axis_tuser != s_curr_axis_tuser,
                         s_prev_axis_tlast != s_curr_axis_tlast} : 2'b00;
        err_d   = (err_clr && err_set == 2'b00) ? 2'b00 : (err_q | err_set);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mode_q      <= '0;
            alpha_q     <= '0;
            thresh_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_c_q      <= '0;
            s1_p_q      <= '0;
            s1_d_q      <= '0;
            s1_ad_q     <= '0;
            s1_last_q   <= 1'b0;
            s1_user_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_user_q    <= 1'b0;
            err_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            err_q <= err_d;
            if (m_valid_q && m_axis_tready && m_user_q)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            if (en) begin
                mode_q     <= mode_d;
                alpha_q    <= alpha_d;
                thresh_q   <= thresh_d;
                s1_valid_q <= acc;
                if (acc) begin
                    s1_c_q    <= s_curr_axis_tdata;
                    s1_p_q    <= s_prev_axis_tdata;
                    s1_d_q    <= s1_d_d;
                    s1_ad_q   <= s1_ad_d;
                    s1_last_q <= s_curr_axis_tlast;
                    s1_user_q <= s_curr_axis_tuser;
                end
                m_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    m_data_q <= m_data_d;
                    m_last_q <= s1_last_q;
                    m_user_q <= s1_user_q;
                end
            end
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign err_flags     = err_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_denoise_blend_axis.sv
// Directed and randomised-stall bench for denoise_blend_axis with a queue-based
// reference model checked on every cycle.
module tb_denoise_blend_axis;

    localparam int CH      = 3;
    localparam int PIX_W   = 8;
    localparam int ALPHA_W = 4;
    localparam int DW      = CH * PIX_W;
    localparam int NBEAT   = 48;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [DW-1:0]     s_prev_axis_tdata, s_curr_axis_tdata, m_axis_tdata;
    logic              s_prev_axis_tvalid, s_prev_axis_tready, s_prev_axis_tlast, s_prev_axis_tuser;
    logic              s_curr_axis_tvalid, s_curr_axis_tready, s_curr_axis_tlast, s_curr_axis_tuser;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [1:0]        cfg_mode;
    logic [ALPHA_W-1:0] cfg_alpha;
    logic [PIX_W-1:0]  cfg_thresh;
    logic              err_clr;
    logic [1:0]        err_flags;
    logic [15:0]       frame_cnt;

    denoise_blend_axis #(.CH(CH), .PIX_W(PIX_W), .ALPHA_W(ALPHA_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_prev_axis_tdata(s_prev_axis_tdata), .s_prev_axis_tvalid(s_prev_axis_tvalid),
        .s_prev_axis_tready(s_prev_axis_tready), .s_prev_axis_tlast(s_prev_axis_tlast),
        .s_prev_axis_tuser(s_prev_axis_tuser),
        .s_curr_axis_tdata(s_curr_axis_tdata), .s_curr_axis_tvalid(s_curr_axis_tvalid),
        .s_curr_axis_tready(s_curr_axis_tready), .s_curr_axis_tlast(s_curr_axis_tlast),
        .s_curr_axis_tuser(s_curr_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .cfg_mode(cfg_mode), .cfg_alpha(cfg_alpha), .cfg_thresh(cfg_thresh),
        .err_clr(err_clr), .err_flags(err_flags), .frame_cnt(frame_cnt)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pixel rule in plain integer arithmetic; floor division for negatives.
    function automatic int pix(input int c, input int p, input int mode, input int alpha, input int th);
        int d, ad, x, q;
        d  = c - p;
        ad = (d < 0) ? -d : d;
        case (mode)
            0: return c;
            1: return p;
            3: return ad;
            default: begin
                if (ad > th) return c;
                x = d * alpha;
                q = (x >= 0) ? x / (1 << ALPHA_W) : -((-x + (1 << ALPHA_W) - 1) / (1 << ALPHA_W));
                return p + q;
            end
        endcase
    endfunction

    function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] c, input logic [DW-1:0] p,
                                                 input int mode, input int alpha, input int th);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++)
            r[i*PIX_W +: PIX_W] = PIX_W'(pix(int'(c[i*PIX_W +: PIX_W]), int'(p[i*PIX_W +: PIX_W]),
                                             mode, alpha, th));
        return r;
    endfunction

    typedef struct { logic [DW-1:0] d; logic l; logic u; } beat_t;
    beat_t exp_q[$];
    beat_t e;

    int          m_mode, m_alpha, m_thresh;
    logic [1:0]  m_err, m_set;
    logic [15:0] m_fcnt;
    logic        held_v;
    logic [DW+1:0] held;
    logic        exp_rdy;

    // Compare process: outputs, flags and handshakes are evaluated mid-cycle
    // for the edge that follows.
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            m_mode = 0; m_alpha = 0; m_thresh = 0;
            m_err = 2'b00; m_fcnt = 16'd0; held_v = 1'b0;
        end else begin
            chk("err_flags", err_flags, m_err);
            chk("frame_cnt", frame_cnt, m_fcnt);
            if (held_v) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_data", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, held);
            end
            exp_rdy = s_prev_axis_tvalid & s_curr_axis_tvalid & (!m_axis_tvalid | m_axis_tready);
            chk("prev_ready", s_prev_axis_tready, exp_rdy);
            chk("curr_ready", s_curr_axis_tready, exp_rdy);
            if (m_axis_tvalid && !m_axis_tready) begin
                held_v = 1'b1;
                held   = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
            end else begin
                held_v = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_axis_tdata, e.d);
                    chk("out_last", m_axis_tlast, e.l);
                    chk("out_user", m_axis_tuser, e.u);
                    if (e.u) m_fcnt = m_fcnt + 16'd1;
                end
            end
            m_set = 2'b00;
            if (exp_rdy) begin
                m_set = {s_prev_axis_tuser != s_curr_axis_tuser, s_prev_axis_tlast != s_curr_axis_tlast};
                if (s_curr_axis_tuser) begin
                    m_mode = int'(cfg_mode); m_alpha = int'(cfg_alpha); m_thresh = int'(cfg_thresh);
                end
                e.d = model_beat(s_curr_axis_tdata, s_prev_axis_tdata, m_mode, m_alpha, m_thresh);
                e.l = s_curr_axis_tlast;
                e.u = s_curr_axis_tuser;
                exp_q.push_back(e);
            end
            if (err_clr && m_set == 2'b00) m_err = 2'b00;
            else                           m_err = m_err | m_set;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic send(input logic [DW-1:0] cd, input logic [DW-1:0] pd,
                        input logic cl, input logic pl, input logic cu, input logic pu, input logic clr);
        s_curr_axis_tdata = cd; s_curr_axis_tlast = cl; s_curr_axis_tuser = cu; s_curr_axis_tvalid = 1'b1;
        s_prev_axis_tdata = pd; s_prev_axis_tlast = pl; s_prev_axis_tuser = pu; s_prev_axis_tvalid = 1'b1;
        err_clr = clr;
        @(negedge aclk);
        chk("accept", s_curr_axis_tready, 1);
        @(posedge aclk); #1;
        s_curr_axis_tvalid = 1'b0; s_prev_axis_tvalid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [DW-1:0] d, input logic u);
        chk({name, "_early"}, m_axis_tvalid, 0);
        @(posedge aclk); #1;
        chk({name, "_valid"}, m_axis_tvalid, 1);
        chk({name, "_data"}, m_axis_tdata, d);
        chk({name, "_user"}, m_axis_tuser, u);
    endtask

    logic [DW-1:0] cur_d[NBEAT];
    logic [DW-1:0] prv_d[NBEAT];
    int  idx, cyc;
    logic a;

    task automatic drive_idx();
        if (idx < NBEAT) begin
            s_curr_axis_tdata = cur_d[idx]; s_prev_axis_tdata = prv_d[idx];
            s_curr_axis_tuser = (idx % 16 == 0); s_prev_axis_tuser = (idx % 16 == 0);
            s_curr_axis_tlast = (idx % 4 == 3);  s_prev_axis_tlast = (idx % 4 == 3);
            s_prev_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_curr_axis_tvalid = ($urandom_range(0, 4) != 0);
        end else begin
            s_prev_axis_tvalid = 1'b0; s_curr_axis_tvalid = 1'b0;
        end
        m_axis_tready = ($urandom_range(0, 2) != 0);
        cfg_mode   = 2'($urandom_range(0, 3));
        cfg_alpha  = ALPHA_W'($urandom_range(0, 15));
        cfg_thresh = PIX_W'($urandom_range(0, 255));
    endtask

    initial begin
        aresetn = 1'b0;
        s_prev_axis_tdata = '0; s_prev_axis_tlast = 0; s_prev_axis_tuser = 0; s_prev_axis_tvalid = 1'b1;
        s_curr_axis_tdata = '0; s_curr_axis_tlast = 0; s_curr_axis_tuser = 0; s_curr_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1; err_clr = 1'b0;
        cfg_mode = 2'd2; cfg_alpha = 4'd8; cfg_thresh = 8'd20;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_readies", {s_prev_axis_tready, s_curr_axis_tready}, 0);
        chk("rst_err", err_flags, 0);
        chk("rst_fcnt", frame_cnt, 0);
        s_prev_axis_tvalid = 1'b0; s_curr_axis_tvalid = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        // Shadow mode is 0 after reset until a SOF beat latches the new config.
        send(24'h646464, 24'h505050, 0, 0, 0, 0, 0);
        expect_out("shadow_rst", 24'h646464, 0);
        send(24'h646464, 24'h505050, 0, 0, 1, 1, 0);
        expect_out("blend_sof", 24'h5A5A5A, 1);
        send(24'h0A64C8, 24'h1E5064, 0, 0, 0, 0, 0);
        expect_out("motion_floor", 24'h145AC8, 0);

        cfg_mode = 2'd0;
        send(24'h646464, 24'h505050, 0, 0, 0, 0, 0);
        expect_out("midline_hold", 24'h5A5A5A, 0);
        send(24'h646464, 24'h505050, 0, 0, 1, 1, 0);
        expect_out("pass_sof", 24'h646464, 1);

        cfg_mode = 2'd3;
        send(24'h10FF00, 24'h2000FF, 0, 0, 1, 1, 0);
        expect_out("absdiff", 24'h10FFFF, 1);

        send(24'h010203, 24'h010203, 0, 1, 0, 0, 0);
        chk("err_tlast", err_flags, 2'b01);
        expect_out("err_beat1", 24'h000000, 0);
        send(24'h010203, 24'h010203, 0, 0, 1, 0, 1);
        chk("err_set_wins", err_flags, 2'b11);
        expect_out("err_beat2", 24'h000000, 1);
        err_clr = 1'b1;
        @(posedge aclk); #1 err_clr = 1'b0;
        chk("err_clear", err_flags, 2'b00);

        aresetn = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("rst2_fcnt", frame_cnt, 0);

        for (int i = 0; i < NBEAT; i++) begin
            cur_d[i] = DW'($urandom);
            prv_d[i] = DW'($urandom);
            if (i % 2 == 0) prv_d[i] = cur_d[i] ^ 24'h070307;
        end
        idx = 0; cyc = 0;
        drive_idx();
        while (idx < NBEAT && cyc < 3000) begin
            @(negedge aclk);
            a = s_curr_axis_tready;
            @(posedge aclk); #1;
            if (a) idx++;
            cyc++;
            drive_idx();
        end
        if (idx < NBEAT) chk("input_timeout", 32'(idx), NBEAT);
        s_prev_axis_tvalid = 1'b0; s_curr_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cyc = 0;
        while ((exp_q.size() > 0 || m_axis_tvalid) && cyc < 200) begin
            @(posedge aclk); #1;
            cyc++;
        end
        @(posedge aclk); #1;
        chk("drain_empty", 32'(exp_q.size()), 0);
        chk("frames_3", frame_cnt, 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/denoise_blend_axis.md
Name: denoise_blend_axis

Overview:
- Second-generation temporal denoise datapath, parametrised in channel count, pixel width and blend precision.
- Joins the previous-frame and current-frame AXI4-Stream inputs beat-for-beat and applies a per-channel, motion-gated recursive blend.
- Drives one AXI4-Stream output and exposes frame-latched configuration, sticky stream-sync error flags and a frame counter.
- Sits between the frame-buffer read path and the output VDMA; its configuration ports are driven by the existing AXI4-Lite register block.

Parameters:
CH, 3, number of channels packed per beat (channel 0 in the LSBs)
PIX_W, 8, bits per channel (unsigned)
ALPHA_W, 4, blend coefficient width; weight = alpha / 2^ALPHA_W

Ports:
aclk  in  1  single clock for the whole block
aresetn  in  1  asynchronous, active-low reset
s_prev_axis_tdata  in  CH*PIX_W  previous-frame pixel
s_prev_axis_tvalid  in  1  previous-frame valid
s_prev_axis_tready  out  1  previous-frame ready
s_prev_axis_tlast  in  1  previous-frame end of line
s_prev_axis_tuser  in  1  previous-frame start of frame
s_curr_axis_tdata  in  CH*PIX_W  current-frame pixel
s_curr_axis_tvalid  in  1  current-frame valid
s_curr_axis_tready  out  1  current-frame ready
s_curr_axis_tlast  in  1  current-frame end of line
s_curr_axis_tuser  in  1  current-frame start of frame
m_axis_tdata  out  CH*PIX_W  filtered pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  end of line (taken from the current stream)
m_axis_tuser  out  1  start of frame (taken from the current stream)
cfg_mode  in  2  0 = pass current, 1 = pass previous, 2 = blend, 3 = |diff| map
cfg_alpha  in  ALPHA_W  weight of the current pixel in blend mode
cfg_thresh  in  PIX_W  motion threshold per channel
err_clr  in  1  one-cycle pulse; clears the sticky error flags
err_flags  out  2  bit0 = tlast mismatch, bit1 = tuser mismatch (sticky)
frame_cnt  out  16  number of output SOF beats accepted downstream; wraps

Behaviour:
- Reset (asynchronous, aresetn = 0):
  - m_axis_tvalid/tlast/tuser = 0, m_axis_tdata = 0.
  - Both input treadies = 0.
  - err_flags = 0, frame_cnt = 0.
  - Shadow configuration: mode = 0, alpha = 0, thresh = 0.
  - Reset mid-frame discards all in-flight beats; there is no recovery beat.
- Pipeline:
  - Two register stages, S1 (difference/select) and S2 (blend/output); m_axis_* is driven directly from S2.
  - Global advance en = !m_axis_tvalid | m_axis_tready; both stages move only when en = 1.
- Input join:
  - s_prev_axis_tready = s_curr_axis_tready = en & s_prev_axis_tvalid & s_curr_axis_tvalid.
  - A beat is accepted only when both streams hand over together; a lone valid stream is never consumed.
- Latency: an accepted beat appears on m_axis 2 cycles later with m_axis_tready held high; full throughput of 1 beat/cycle.
- Configuration latch:
  - On an accepted beat with s_curr_axis_tuser = 1, the shadow registers load cfg_mode/cfg_alpha/cfg_thresh, and those values apply to that beat.
  - Otherwise the shadow values hold, so configuration never changes mid-frame.
- Per-channel arithmetic (c = curr, p = prev, both unsigned PIX_W):
  - d = c - p, signed on PIX_W+1 bits; ad = |d|.
  - mode 0: out = c. mode 1: out = p. mode 3: out = ad (fits PIX_W).
  - mode 2, ad > thresh: out = c (motion bypass).
  - mode 2, ad <= thresh: out = p + ((d * alpha) >>> ALPHA_W), arithmetic shift (floor).
  - The mode-2 blend result always lies between p and c; no saturation needed. alpha = 0 gives p exactly.
- Sideband: m_axis_tlast/tuser come from the current stream and are pipelined alongside the data.
- Sync errors:
  - On an accepted beat, prev.tlast != curr.tlast sets bit0; prev.tuser != curr.tuser sets bit1.
  - Flags are sticky. If err_clr and a new set happen in the same cycle, set wins.
- frame_cnt: increments on m_axis_tvalid & m_axis_tready & m_axis_tuser; wraps 0xFFFF -> 0.
- Backpressure: while m_axis_tready = 0 with valid output pending, m_axis_* holds stable and both input treadies are 0.

Test Plan:
- Reset then CH=3, PIX_W=8, mode 2, alpha 8, thresh 20; beat curr=0x646464, prev=0x505050 with tuser=1 -> output 0x5A5A5A two cycles later, tuser=1.
- Same configuration, curr ch0=200, prev ch0=100 (ad=100 > 20) -> ch0 output 200; mode 2, alpha 8, curr=10, prev=30 -> output 20 (d = -20, floor -10).
- Mode 3, curr=0x10FF00, prev=0x2000FF -> output 0x10FFFF.
- Change cfg_mode from 2 to 0 mid-line -> no effect until the next curr tuser beat, where passthrough starts on that beat.
- Prev tlast=1 with curr tlast=0 on a joined beat -> err_flags=01; err_clr pulsed together with a new tuser mismatch -> err_flags=11.
- Random m_axis_tready toggling and prev valid stalls across 3 frames of 4x4 -> no data loss or duplication, output order preserved, frame_cnt=3, data stable while stalled.
